addr_nu_serial_chk: RTL and testbench

ADDR_NU_SERIAL_CHK -- requirements
Module: addr_nu_serial_chk

---
 rtl/addr_nu_serial_chk.sv | 163 ++++++++++++++++
 tb/tb_addr_nu_serial_chk.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/addr_nu_serial_chk.sv
// Digit-serial adder (DIGIT bits per cycle) with a mod-3 residue check on every result.
// A saturating counter records how many faulty results were handed to the consumer.
module addr_nu_serial_chk #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             fault,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int K     = WIDTH / DIGIT;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bit i of a binary number carries weight 1 (even i) or 2 (odd i) modulo 3.
  function automatic logic [1:0] mod3(input logic [WIDTH:0] v);
    logic [1:0] acc;
    logic [1:0] w;
    logic [2:0] t;
    acc = 2'd0;
    for (int i = 0; i <= WIDTH; i++) begin
      w = (i % 2 == 0) ? 2'd1 : 2'd2;
      if (v[i]) begin
        t   = {1'b0, acc} + {1'b0, w};
        acc = (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
      end
    end
    return acc;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_inj;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_rin;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;

  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_digit_ext;
  logic [WIDTH-1:0] w_next_result;
  logic [WIDTH-1:0] w_final_result;
  logic [WIDTH:0]   w_final_sum;
  logic [WIDTH:0]   w_in_sum;
  logic             w_accept;
  logic             w_handshake;
  logic             w_last;

  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

  always_comb begin
    w_digit_ext = '0;
    w_digit_ext[DIGIT-1:0] = w_dsum[DIGIT-1:0];
  end

  // New digits enter at the top so that after K shifts the first digit sits at bit 0.
  assign w_next_result  = (r_result >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));
  assign w_final_result = w_next_result ^ WIDTH'(r_inj);
  assign w_final_sum    = {w_dsum[DIGIT], w_final_result};
  assign w_in_sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  assign w_accept    = (r_state == IDLE) && r_in_ready && in_valid;
  assign w_handshake = r_out_valid && out_ready;
  assign w_last      = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_inj       <= 1'b0;
      r_idx       <= '0;
      r_rin       <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_inj      <= inj;
            r_carry    <= cin;
            r_idx      <= '0;
            r_result   <= '0;
            r_rin      <= mod3(w_in_sum);
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_dsum[DIGIT];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_result    <= w_final_result;
            r_fault     <= (mod3(w_final_sum) != r_rin);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_result <= w_next_result;
          end
        end
        DONE: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_fault     <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase

      // Clearing takes priority over counting a faulty delivery on the same edge.
      if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_handshake && r_fault && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = {r_carry, r_result};
  assign fault     = r_fault;
  assign fault_cnt = r_cnt;

endmodule

// File: tb/tb_addr_nu_serial_chk.sv
// Scoreboard bench for addr_nu_serial_chk (WIDTH=8, DIGIT=2, CNT_W=2).
// Stimulus pushes hand-computed results; a negedge monitor pops them on each handshake.
module tb_addr_nu_serial_chk;

  typedef struct {
    logic [8:0] sum;
    logic       fault;
  } exp_t;

  logic       clk;
  logic       rstN;
  logic       inValid;
  logic       inReady;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       inj;
  logic       outValid;
  logic       outReady;
  logic [8:0] sum;
  logic       fault;
  logic       clrCnt;
  logic [1:0] faultCnt;

  exp_t expQ[$];
  int   checks;
  int   errors;
  int   expCnt;

  addr_nu_serial_chk #(.WIDTH(8), .DIGIT(2), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .inj       (inj),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sum),
    .fault     (fault),
    .clr_cnt   (clrCnt),
    .fault_cnt (faultCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Any result presented while the consumer is ready is retired at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", {23'd0, sum}, {23'd0, e.sum});
        checkOutput("fault", {31'd0, fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                               input logic tinj, input logic [8:0] expSum, input logic expFault,
                               input int stall, input logic clrOnHs);
    int   n;
    exp_t e;
    outReady = (stall == 0);
    n = 0;
    while (!inReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inReady) checkOutput("accept_timeout", 0, 1);
    a = ta; b = tb; cin = tcin; inj = tinj; inValid = 1'b1;
    e.sum = expSum;
    e.fault = expFault;
    expQ.push_back(e);
    @(posedge clk); #1;
    inValid = 1'b0;
    n = 0;
    while (!outValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("latency", n, 4);
    for (int i = 0; i < stall; i++) begin
      checkOutput("stall_valid", {31'd0, outValid}, 1);
      checkOutput("stall_sum", {23'd0, sum}, {23'd0, expSum});
      checkOutput("stall_in_ready", {31'd0, inReady}, 0);
      if (i == 1) begin
        a = 8'h11; b = 8'h22; cin = 1'b0; inj = 1'b0; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    clrCnt = clrOnHs;
    @(posedge clk); #1;
    clrCnt = 1'b0;
    if (clrOnHs) expCnt = 0;
    else if (expFault && expCnt < 3) expCnt++;
    checkOutput("ready_after_hs", {31'd0, inReady}, 1);
    checkOutput("valid_after_hs", {31'd0, outValid}, 0);
    checkOutput("fault_cnt", {30'd0, faultCnt}, expCnt);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int sawValid;
    checks = 0; errors = 0; expCnt = 0;
    rstN = 1'b0; inValid = 1'b0; a = '0; b = '0; cin = 1'b0; inj = 1'b0;
    outReady = 1'b1; clrCnt = 1'b0;
    #2;
    checkOutput("reset_in_ready", {31'd0, inReady}, 0);
    checkOutput("reset_out_valid", {31'd0, outValid}, 0);
    checkOutput("reset_sum", {23'd0, sum}, 0);
    checkOutput("reset_fault", {31'd0, fault}, 0);
    checkOutput("reset_fault_cnt", {30'd0, faultCnt}, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_release", {31'd0, inReady}, 1);

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0, 0, 1'b0);
    applyStimulus(8'h3C, 8'h47, 1'b1, 1'b0, 9'h084, 1'b0, 0, 1'b0);
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1, 9'h031, 1'b1, 0, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 1'b0, 5, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0, 0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 0, 1'b0);

    // Abort an operation in its second RUN cycle; nothing may be delivered for it.
    a = 8'h12; b = 8'h34; cin = 1'b0; inj = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    expCnt = 0;
    checkOutput("abort_out_valid", {31'd0, outValid}, 0);
    checkOutput("abort_sum", {23'd0, sum}, 0);
    checkOutput("abort_fault", {31'd0, fault}, 0);
    checkOutput("abort_in_ready", {31'd0, inReady}, 0);
    checkOutput("abort_fault_cnt", {30'd0, faultCnt}, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (outValid) sawValid++;
    end
    checkOutput("no_result_after_abort", sawValid, 0);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 1'b0, 0, 1'b0);

    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 9'h003, 1'b1, 0, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b1, 9'h101, 1'b1, 0, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1, 9'h101, 1'b1, 0, 1'b0);
    applyStimulus(8'h07, 8'h02, 1'b0, 1'b1, 9'h008, 1'b1, 0, 1'b0);
    applyStimulus(8'h07, 8'h02, 1'b0, 1'b1, 9'h008, 1'b1, 0, 1'b1);
    applyStimulus(8'h07, 8'h02, 1'b0, 1'b1, 9'h008, 1'b1, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
